// File: rtl/pwm_generator.sv
// Prescaled PWM generator. New duty/period/prescale settings are held in a
// pending shadow and only become active at a period boundary.
module pwm_generator #(
    parameter int WORD_LENGTH    = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      load,
    input  logic [WORD_LENGTH-1:0]    duty_in,
    input  logic [WORD_LENGTH-1:0]    period_in,
    input  logic [PRESCALE_WIDTH-1:0] prescale_in,
    output logic                      pwm_out,
    output logic                      period_done,
    output logic                      busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [WORD_LENGTH-1:0]    CNT_ONE = {{(WORD_LENGTH-1){1'b0}}, 1'b1};
    localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    state_t                    state_q;
    logic [WORD_LENGTH-1:0]    cnt_q;
    logic [PRESCALE_WIDTH-1:0] pre_cnt_q;
    logic [WORD_LENGTH-1:0]    duty_act_q;
    logic [WORD_LENGTH-1:0]    period_act_q;
    logic [PRESCALE_WIDTH-1:0] prescale_act_q;
    logic [WORD_LENGTH-1:0]    duty_pend_q;
    logic [WORD_LENGTH-1:0]    period_pend_q;
    logic [PRESCALE_WIDTH-1:0] prescale_pend_q;
    logic                      pend_valid_q;
    logic                      tick_s;
    logic                      boundary_s;

    // Outputs are decoded straight from registered state so the pin sees no extra cycle of lag.
    assign tick_s      = (state_q == RUN) && (pre_cnt_q == prescale_act_q);
    assign boundary_s  = tick_s && (cnt_q == period_act_q);
    assign period_done = boundary_s;
    assign busy        = (state_q == RUN);
    assign pwm_out     = (state_q == RUN) && (cnt_q < duty_act_q);

    // Control FSM, prescaler, main counter and the active/pending setting registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            cnt_q           <= '0;
            pre_cnt_q       <= '0;
            duty_act_q      <= '0;
            period_act_q    <= '0;
            prescale_act_q  <= '0;
            duty_pend_q     <= '0;
            period_pend_q   <= '0;
            prescale_pend_q <= '0;
            pend_valid_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_q     <= '0;
                    pre_cnt_q <= '0;
                    if (load) begin
                        duty_pend_q     <= duty_in;
                        period_pend_q   <= period_in;
                        prescale_pend_q <= prescale_in;
                        pend_valid_q    <= 1'b1;
                    end
                    // Starting always uses the live inputs; anything pending is discarded.
                    if (enable) begin
                        duty_act_q     <= duty_in;
                        period_act_q   <= period_in;
                        prescale_act_q <= prescale_in;
                        pend_valid_q   <= 1'b0;
                        state_q        <= RUN;
                    end
                end
                RUN: begin
                    if (tick_s) begin
                        pre_cnt_q <= '0;
                        cnt_q     <= boundary_s ? '0 : cnt_q + CNT_ONE;
                    end else begin
                        pre_cnt_q <= pre_cnt_q + PRE_ONE;
                    end
                    if (boundary_s) begin
                        // A load landing on the boundary bypasses the shadow entirely.
                        if (load) begin
                            duty_act_q     <= duty_in;
                            period_act_q   <= period_in;
                            prescale_act_q <= prescale_in;
                            pend_valid_q   <= 1'b0;
                        end else if (pend_valid_q) begin
                            duty_act_q     <= duty_pend_q;
                            period_act_q   <= period_pend_q;
                            prescale_act_q <= prescale_pend_q;
                            pend_valid_q   <= 1'b0;
                        end
                        if (!enable) begin
                            state_q <= IDLE;
                        end
                    end else if (load) begin
                        duty_pend_q     <= duty_in;
                        period_pend_q   <= period_in;
                        prescale_pend_q <= prescale_in;
                        pend_valid_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_generator.sv
// Directed bench for pwm_generator: waveform captures are compared against
// hand-computed bit patterns (bit k = sample k clocks after the capture start).
module tb_pwm_generator;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       load;
    logic [7:0] duty_in;
    logic [7:0] period_in;
    logic [7:0] prescale_in;
    logic       pwm_out;
    logic       period_done;
    logic       busy;

    int checks = 0;
    int errors = 0;
    logic [63:0] pw;
    logic [63:0] pd;
    logic [63:0] bz;

    pwm_generator #(.WORD_LENGTH(8), .PRESCALE_WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .duty_in    (duty_in),
        .period_in  (period_in),
        .prescale_in(prescale_in),
        .pwm_out    (pwm_out),
        .period_done(period_done),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic capture(input int n, output logic [63:0] p_w, output logic [63:0] p_d,
                           output logic [63:0] b_z);
        p_w = '0;
        p_d = '0;
        b_z = '0;
        for (int i = 0; i < n; i++) begin
            p_w[i] = pwm_out;
            p_d[i] = period_done;
            b_z[i] = busy;
            step(1);
        end
    endtask

    task automatic pulse_load(input logic [7:0] d, input logic [7:0] p, input logic [7:0] s);
        duty_in     = d;
        period_in   = p;
        prescale_in = s;
        load        = 1'b1;
        step(1);
        load        = 1'b0;
    endtask

    initial begin
        reset       = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        duty_in     = 8'd0;
        period_in   = 8'd0;
        prescale_in = 8'd0;
        #3;
        check("reset_pwm", {63'd0, pwm_out}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, period_done}, 64'd0);
        step(2);
        reset = 1'b1;
        step(1);
        check("idle_busy", {63'd0, busy}, 64'd0);

        // Basic 30%: sample 0 is the first clock in RUN
        duty_in = 8'd3; period_in = 8'd9; prescale_in = 8'd0; enable = 1'b1;
        step(1);
        capture(20, pw, pd, bz);
        check("basic_pwm", pw, 64'h01C07);
        check("basic_done", pd, 64'h80200);
        check("basic_busy", bz, 64'hFFFFF);

        // Prescaled settings queued mid-period, active from the next boundary
        pulse_load(8'd2, 8'd3, 8'd4);
        step(8);
        check("pre_q_done", {63'd0, period_done}, 64'd1);
        check("pre_q_pwm", {63'd0, pwm_out}, 64'd0);
        step(1);
        capture(40, pw, pd, bz);
        check("presc_pwm", pw, 64'h003FF003FF);
        check("presc_done", pd, 64'h8000080000);

        // Back to 3/9/0, then shadow update tests
        pulse_load(8'd3, 8'd9, 8'd0);
        step(19);
        capture(5, pw, pd, bz);
        check("shadow_cur_head", pw, 64'h07);
        pulse_load(8'd7, 8'd9, 8'd0);
        capture(4, pw, pd, bz);
        check("shadow_cur_tail_pwm", pw, 64'h0);
        check("shadow_cur_tail_done", pd, 64'h8);
        capture(10, pw, pd, bz);
        check("shadow_next_pwm", pw, 64'h07F);
        check("shadow_next_done", pd, 64'h200);
        step(3);
        pulse_load(8'd4, 8'd9, 8'd0);
        step(2);
        pulse_load(8'd1, 8'd9, 8'd0);
        capture(3, pw, pd, bz);
        check("lastwin_cur_pwm", pw, 64'h0);
        check("lastwin_cur_done", pd, 64'h4);
        capture(10, pw, pd, bz);
        check("lastwin_pwm", pw, 64'h001);
        check("lastwin_done", pd, 64'h200);

        // Boundary collision overrides a stale pending duty=2
        step(4);
        pulse_load(8'd2, 8'd9, 8'd0);
        step(4);
        check("coll_done", {63'd0, period_done}, 64'd1);
        pulse_load(8'd5, 8'd9, 8'd0);
        capture(10, pw, pd, bz);
        check("coll_pwm", pw, 64'h01F);
        check("coll_period_done", pd, 64'h200);
        capture(10, pw, pd, bz);
        check("coll_stable_pwm", pw, 64'h01F);

        // Extremes
        pulse_load(8'd0, 8'd9, 8'd0);
        step(9);
        capture(10, pw, pd, bz);
        check("duty0_pwm", pw, 64'h0);
        check("duty0_done", pd, 64'h200);
        pulse_load(8'd12, 8'd9, 8'd0);
        step(9);
        capture(10, pw, pd, bz);
        check("duty12_pwm", pw, 64'h3FF);
        check("duty12_busy", bz, 64'h3FF);

        // Graceful stop: enable dropped at cnt=4
        pulse_load(8'd3, 8'd9, 8'd0);
        step(13);
        enable = 1'b0;
        capture(6, pw, pd, bz);
        check("stop_pwm", pw, 64'h00);
        check("stop_done", pd, 64'h20);
        check("stop_busy", bz, 64'h3F);
        check("stopped_busy", {63'd0, busy}, 64'd0);
        check("stopped_pwm", {63'd0, pwm_out}, 64'd0);

        // IDLE load goes to pending; start uses live inputs and clears pending
        pulse_load(8'd6, 8'd9, 8'd0);
        check("idle_load_busy", {63'd0, busy}, 64'd0);
        duty_in = 8'd3; period_in = 8'd9; prescale_in = 8'd0; enable = 1'b1;
        step(1);
        capture(20, pw, pd, bz);
        check("restart_pwm", pw, 64'h01C07);
        check("restart_done", pd, 64'h80200);

        // Asynchronous reset at cnt=2 while high
        step(2);
        check("prereset_pwm", {63'd0, pwm_out}, 64'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async_pwm", {63'd0, pwm_out}, 64'd0);
        check("async_busy", {63'd0, busy}, 64'd0);
        duty_in = 8'd4;
        #3;
        reset = 1'b1;
        step(1);
        capture(10, pw, pd, bz);
        check("postreset_pwm", pw, 64'h00F);
        check("postreset_done", pd, 64'h200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
